// File: rtl/demux2_stream_pkg.sv
// rtl/demux2_stream_pkg.sv - shared channel codes and routed-entry type for demux2_stream
package demux2_stream_pkg;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam int DATA_W    = 32;
  localparam int BUF_DEPTH = 2;

  typedef struct packed {
    logic              sel;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/demux2_stream_if.sv
// rtl/demux2_stream_if.sv - producer/consumer handshake bundle for demux2_stream
interface demux2_stream_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [CW-1:0]    count;

  modport master (
    output flush, in_valid, in_sel, in_data, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data, count
  );

  modport slave (
    input  flush, in_valid, in_sel, in_data, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data, count
  );

endinterface

// File: rtl/demux2_stream_sel_fifo.sv
// rtl/demux2_stream_sel_fifo.sv - DEPTH x W synchronous FIFO with push/pop/flush and occupancy count
module demux2_stream_sel_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Storage carries no reset; only the pointers and count define what is live.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CNT_MAX);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/demux2_stream.sv
// rtl/demux2_stream.sv - in-order 1-to-2 stream router; the head word goes to the channel its select names
module demux2_stream
  import demux2_stream_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  demux2_stream_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic             sel;
    logic [WIDTH-1:0] data;
  } route_t;

  route_t        w_push_entry;
  route_t        w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_head_ch0;
  logic          w_head_ch1;
  logic [CW-1:0] w_count;

  assign w_push_entry = route_t'{sel: bus.in_sel, data: bus.in_data};

  // Ready depends only on occupancy, so a pop never lets a push through in the same cycle.
  assign bus.in_ready = !w_full;
  assign w_push       = bus.in_valid && !w_full;

  assign w_head_ch0 = !w_empty && (w_head.sel == CH0);
  assign w_head_ch1 = !w_empty && (w_head.sel == CH1);

  assign bus.out0_valid = w_head_ch0;
  assign bus.out1_valid = w_head_ch1;
  assign bus.out0_data  = w_head_ch0 ? w_head.data : '0;
  assign bus.out1_data  = w_head_ch1 ? w_head.data : '0;

  assign w_pop     = (w_head_ch0 && bus.out0_ready) || (w_head_ch1 && bus.out1_ready);
  assign bus.count = w_count;

  demux2_stream_sel_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (bus.flush),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_demux2_stream.sv
// tb/tb_demux2_stream.sv - randomized and directed bench for demux2_stream against a queue model
module tb_demux2_stream;
  import demux2_stream_pkg::*;

  localparam int W = 32;
  localparam int D = 2;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  entry_t q[$];

  demux2_stream_if #(.WIDTH(W), .DEPTH(D)) ifc ();

  demux2_stream #(.WIDTH(W), .DEPTH(D)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs follow purely from the queue: head word, its channel, and occupancy.
  task automatic compare_model(input string tag);
    logic        hv;
    logic        hs;
    logic [31:0] hd;
    hv = (q.size() != 0);
    hs = hv ? q[0].sel : 1'b0;
    hd = hv ? q[0].data : 32'h0;
    check({tag, ".in_ready"}, ifc.in_ready, 64'(q.size() != D));
    check({tag, ".v0"}, ifc.out0_valid, 64'(hv && hs == CH0));
    check({tag, ".v1"}, ifc.out1_valid, 64'(hv && hs == CH1));
    check({tag, ".d0"}, ifc.out0_data, (hv && hs == CH0) ? 64'(hd) : 64'h0);
    check({tag, ".d1"}, ifc.out1_data, (hv && hs == CH1) ? 64'(hd) : 64'h0);
    check({tag, ".count"}, ifc.count, 64'(q.size()));
  endtask

  // Drive one cycle from negedge to negedge, advance the model at the edge, then compare.
  task automatic step(input string tag, input logic v, input logic s, input logic [31:0] d,
                      input logic r0, input logic r1, input logic fl, output logic accepted);
    int   n;
    logic do_push;
    logic do_pop;
    ifc.in_valid   = v;
    ifc.in_sel     = s;
    ifc.in_data    = d;
    ifc.out0_ready = r0;
    ifc.out1_ready = r1;
    ifc.flush      = fl;
    n       = q.size();
    do_push = v && (n < D);
    do_pop  = (n > 0) && ((q[0].sel == CH0 && r0) || (q[0].sel == CH1 && r1));
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(entry_t'{sel: s, data: d});
    end
    accepted = do_push;
    @(negedge clk);
    compare_model(tag);
  endtask

  logic        acc;
  logic        cur_v;
  logic        cur_s;
  logic [31:0] cur_d;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n          = 1'b0;
    ifc.flush      = 1'b0;
    ifc.in_valid   = 1'b0;
    ifc.in_sel     = 1'b0;
    ifc.in_data    = '0;
    ifc.out0_ready = 1'b0;
    ifc.out1_ready = 1'b0;
    #1;
    compare_model("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single word on channel 0
    step("t1a", 1, 0, 32'hAAAA0001, 1, 0, 0, acc);
    check("t1.v0", ifc.out0_valid, 1);
    check("t1.d0", ifc.out0_data, 64'hAAAA0001);
    check("t1.v1", ifc.out1_valid, 0);
    step("t1b", 0, 0, 0, 1, 0, 0, acc);
    check("t1.count", ifc.count, 0);

    // alternating channels at full rate
    for (int i = 1; i <= 4; i++) begin
      step("t2", 1, 1'((i - 1) % 2), 32'(i), 1, 1, 0, acc);
      check("t2.chan", (i % 2 == 1) ? ifc.out0_valid : ifc.out1_valid, 1);
      check("t2.data", (i % 2 == 1) ? ifc.out0_data : ifc.out1_data, 64'(i));
    end
    step("t2z", 0, 0, 0, 1, 1, 0, acc);
    check("t2.count", ifc.count, 0);

    // head-of-line block, then full-buffer release with a held word
    step("t3a", 1, 1, 32'h11, 1, 0, 0, acc);
    step("t3b", 1, 0, 32'h22, 1, 0, 0, acc);
    check("t3.count", ifc.count, 2);
    check("t3.in_ready", ifc.in_ready, 0);
    check("t3.v0", ifc.out0_valid, 0);
    step("t4a", 1, 0, 32'h33, 1, 1, 0, acc);
    check("t4.no_push_when_full", acc, 0);
    check("t4.in_ready_after_pop", ifc.in_ready, 1);
    check("t4.d0", ifc.out0_data, 64'h22);
    step("t4b", 1, 0, 32'h33, 1, 1, 0, acc);
    check("t4.held_accepted", acc, 1);
    check("t4.d0b", ifc.out0_data, 64'h33);
    step("t4c", 0, 0, 0, 1, 1, 0, acc);
    check("t4.count", ifc.count, 0);

    // flush while full and while a push is offered
    step("t5a", 1, 0, 32'h44, 0, 0, 0, acc);
    step("t5b", 1, 1, 32'h55, 0, 0, 0, acc);
    step("t5c", 1, 0, 32'h66, 1, 1, 1, acc);
    check("t5.count", ifc.count, 0);
    step("t5d", 1, 0, 32'h77, 0, 0, 0, acc);
    step("t5e", 1, 1, 32'h88, 0, 0, 1, acc);
    check("t5.flush_push_count", ifc.count, 0);
    check("t5.flush_push_v1", ifc.out1_valid, 0);
    step("t5f", 0, 0, 0, 1, 1, 0, acc);
    check("t5.never_delivered", ifc.out1_valid, 0);

    // asynchronous reset between edges
    step("t6a", 1, 0, 32'h99, 0, 0, 0, acc);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    check("t6.v0", ifc.out0_valid, 0);
    check("t6.in_ready", ifc.in_ready, 1);
    check("t6.count", ifc.count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step("t6b", 1, 1, 32'hAB, 0, 1, 0, acc);
    check("t6.v1", ifc.out1_valid, 1);
    check("t6.d1", ifc.out1_data, 64'hAB);
    step("t6c", 0, 0, 0, 0, 1, 0, acc);

    // random traffic; the producer holds its word until it is taken
    cur_v = 1'b0;
    cur_s = 1'b0;
    cur_d = '0;
    for (int i = 0; i < 600; i++) begin
      if (!cur_v || acc) begin
        cur_v = ($urandom_range(0, 3) != 0);
        cur_s = 1'($urandom_range(0, 1));
        cur_d = $urandom;
      end
      step("rnd", cur_v, cur_s, cur_d, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 31) == 0), acc);
      if (ifc.flush) acc = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
